// File: rtl/mem_pkg.sv
// Shared memory-interface constants and helpers for the 5-stage core data path.
package mem_pkg;

    localparam logic [3:0] WE_B0   = 4'b0001;
    localparam logic [3:0] WE_B1   = 4'b0010;
    localparam logic [3:0] WE_B2   = 4'b0100;
    localparam logic [3:0] WE_B3   = 4'b1000;
    localparam logic [3:0] WE_H_LO = 4'b0011;
    localparam logic [3:0] WE_H_HI = 4'b1100;
    localparam logic [3:0] WE_W    = 4'b1111;

    localparam logic [3:0] ST_B = 4'b0100;
    localparam logic [3:0] ST_H = 4'b0101;
    localparam logic [3:0] ST_W = 4'b0110;

    localparam logic [31:0] RESET_PC  = 32'h1c00_0000;
    localparam logic [31:0] DATA_BASE = 32'h1c00_0000;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    // Byte-enable patterns carry the access size; the address only has to agree with it.
    function automatic logic we_misaligned(input logic [3:0] we, input logic [1:0] lo);
        case (we)
            4'b0000, WE_B0, WE_B1, WE_B2, WE_B3: return 1'b0;
            WE_H_LO, WE_H_HI:                    return lo[0];
            WE_W:                                return lo != 2'b00;
            default:                             return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_sram_resp_pipe.sv
// Response delay line: STAGES-deep {valid, resp} shift register frozen as a whole by hold_i.
module data_sram_resp_pipe
    import mem_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  hold_i,
    input  logic  in_vld_i,
    input  resp_t in_resp_i,
    output logic  out_vld_o,
    output resp_t out_resp_o
);

    logic  [STAGES-1:0] vld_q;
    resp_t [STAGES-1:0] resp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            resp_q <= '0;
        end else if (!hold_i) begin
            vld_q[0]  <= in_vld_i;
            resp_q[0] <= in_resp_i;
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s]  <= vld_q[s-1];
                resp_q[s] <= resp_q[s-1];
            end
        end
    end

    assign out_vld_o  = vld_q[STAGES-1];
    assign out_resp_o = resp_q[STAGES-1];

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: word RAM with byte-lane writes, range/alignment checks and a fixed-latency reply.
module data_sram_resp
    import mem_pkg::*;
#(
    parameter int          ADDR_W = 10,
    parameter logic [31:0] BASE   = DATA_BASE,
    parameter int          RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_en,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic        resp_stall
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("data_sram_resp: RD_LAT must be in 1..4");
    end

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       off;
    logic [ADDR_W-1:0] idx;
    logic              oor, err, accept, hold, wr_en;
    logic [31:0]       rd_word, merged;
    resp_t             st_in, st_out;

    assign hold      = resp_valid && resp_stall;
    assign req_ready = !hold;
    assign accept    = req_en && req_ready;

    assign off = req_addr - BASE;
    assign idx = off[ADDR_W+1:2];
    // Upper offset bits catch both overshoot and (via wraparound) addresses below BASE.
    assign oor = (req_addr < BASE) || (off[31:ADDR_W+2] != '0);
    assign err = oor || we_misaligned(req_we, off[1:0]);

    assign rd_word = mem_q[idx];
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (req_we[i]) merged[8*i +: 8] = req_wdata[8*i +: 8];
        end
    end

    // Reset is folded into the enable so an edge coinciding with reset cannot commit a write.
    assign wr_en = accept && !err && (req_we != 4'b0000) && !reset;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[idx] <= merged;
    end

    assign st_in.err  = accept && err;
    assign st_in.data = (accept && !err) ? merged : 32'h0;

    data_sram_resp_pipe #(.STAGES(RD_LAT)) u_pipe (
        .clk        (clk),
        .reset      (reset),
        .hold_i     (hold),
        .in_vld_i   (accept),
        .in_resp_i  (st_in),
        .out_vld_o  (resp_valid),
        .out_resp_o (st_out)
    );

    assign resp_rdata = st_out.data;
    assign resp_err   = st_out.err;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench: three responders (RD_LAT 1/2/3) share one request bus; each has its own stall.
module tb_data_sram_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_en;
    logic [3:0]  req_we;
    logic [31:0] req_addr, req_wdata;
    logic        st1, st2, st3;
    logic        rdy1, rdy2, rdy3, v1, v2, v3, e1, e2, e3;
    logic [31:0] d1, d2, d3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_sram_resp #(.RD_LAT(1)) u1 (.clk(clk), .reset(reset), .req_en(req_en), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy1), .resp_valid(v1),
        .resp_rdata(d1), .resp_err(e1), .resp_stall(st1));
    data_sram_resp #(.RD_LAT(2)) u2 (.clk(clk), .reset(reset), .req_en(req_en), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy2), .resp_valid(v2),
        .resp_rdata(d2), .resp_err(e2), .resp_stall(st2));
    data_sram_resp #(.RD_LAT(3)) u3 (.clk(clk), .reset(reset), .req_en(req_en), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy3), .resp_valid(v3),
        .resp_rdata(d3), .resp_err(e3), .resp_stall(st3));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
        req_en = en; req_we = we; req_addr = a; req_wdata = wd;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];
    logic [31:0] pre [4];

    initial begin
        vecs[0]  = '{4'b1111, 32'h1c000010, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{4'b0000, 32'h1c000010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{4'b0010, 32'h1c000011, 32'h0000AA00, 32'hDEADAAEF, 1'b0};
        vecs[3]  = '{4'b0000, 32'h1c000010, 32'h0,        32'hDEADAAEF, 1'b0};
        vecs[4]  = '{4'b1100, 32'h1c000012, 32'h12340000, 32'h1234AAEF, 1'b0};
        vecs[5]  = '{4'b0000, 32'h1c000010, 32'h0,        32'h1234AAEF, 1'b0};
        vecs[6]  = '{4'b1111, 32'h1c000012, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[7]  = '{4'b0000, 32'h1c000010, 32'h0,        32'h1234AAEF, 1'b0};
        vecs[8]  = '{4'b0000, 32'h1c001000, 32'h0,        32'h0,        1'b1};
        vecs[9]  = '{4'b0000, 32'h1bfffffc, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{4'b0101, 32'h1c000010, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[11] = '{4'b0011, 32'h1c000011, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[12] = '{4'b0001, 32'h1c000013, 32'h00000055, 32'h1234AA55, 1'b0};
        vecs[13] = '{4'b0000, 32'h1c000010, 32'h0,        32'h1234AA55, 1'b0};
        vecs[14] = '{4'b1111, 32'h1c000ffc, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
        vecs[15] = '{4'b0000, 32'h1c000ffc, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[16] = '{4'b1111, 32'h1c000020, 32'h11111111, 32'h11111111, 1'b0};
        vecs[17] = '{4'b1111, 32'h1c000024, 32'h22222222, 32'h22222222, 1'b0};
        vecs[18] = '{4'b1111, 32'h1c000028, 32'h33333333, 32'h33333333, 1'b0};
        vecs[19] = '{4'b1111, 32'h1c00002c, 32'h44444444, 32'h44444444, 1'b0};
        pre = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

        st1 = 0; st2 = 0; st3 = 0;
        drive(0, 4'b0, 32'h0, 32'h0);
        reset = 1'b1;
        #12;
        chk("rst_v1", {31'b0, v1}, 0);
        chk("rst_v2", {31'b0, v2}, 0);
        chk("rst_v3", {31'b0, v3}, 0);
        chk("rst_d1", d1, 0);
        chk("rst_e1", {31'b0, e1}, 0);
        chk("rst_rdy1", {31'b0, rdy1}, 1);
        @(negedge clk); reset = 1'b0;

        // RD_LAT=1: each request answers right after its accept edge, back to back.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            edge_sample();
            chk($sformatf("v%0d_valid", i), {31'b0, v1}, 1);
            chk($sformatf("v%0d_rdata", i), d1, vecs[i].rdata);
            chk($sformatf("v%0d_err", i), {31'b0, e1}, {31'b0, vecs[i].err});
        end
        @(negedge clk); drive(0, 4'b0, 32'h0, 32'h0);
        edge_sample();
        chk("l1_valid_drop", {31'b0, v1}, 0);
        repeat (4) edge_sample();

        // RD_LAT=3: four reads on consecutive edges; answers after edges 2..5.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k < 4) drive(1, 4'b0, 32'h1c000020 + 32'(4 * k), 32'h0);
            else       drive(0, 4'b0, 32'h0, 32'h0);
            edge_sample();
            if (k >= 2 && k <= 5) begin
                chk($sformatf("l3_valid%0d", k), {31'b0, v3}, 1);
                chk($sformatf("l3_data%0d", k), d3, pre[k-2]);
            end else begin
                chk($sformatf("l3_idle%0d", k), {31'b0, v3}, 0);
            end
        end
        repeat (3) edge_sample();

        // RD_LAT=2 backpressure: stall two cycles from the first response.
        @(negedge clk); drive(1, 4'b0, 32'h1c000020, 32'h0);
        edge_sample();
        chk("bp_v_e0", {31'b0, v2}, 0);
        @(negedge clk); drive(1, 4'b0, 32'h1c000024, 32'h0);
        edge_sample();
        chk("bp_v_e1", {31'b0, v2}, 1);
        chk("bp_d_e1", d2, pre[0]);
        @(negedge clk); drive(1, 4'b0, 32'h1c000028, 32'h0); st2 = 1;
        #1 chk("bp_rdy_stall_a", {31'b0, rdy2}, 0);
        edge_sample();
        chk("bp_hold_v_a", {31'b0, v2}, 1);
        chk("bp_hold_d_a", d2, pre[0]);
        @(negedge clk);
        #1 chk("bp_rdy_stall_b", {31'b0, rdy2}, 0);
        edge_sample();
        chk("bp_hold_d_b", d2, pre[0]);
        @(negedge clk); st2 = 0;
        #1 chk("bp_rdy_free", {31'b0, rdy2}, 1);
        edge_sample();
        chk("bp_v_r1", {31'b0, v2}, 1);
        chk("bp_d_r1", d2, pre[1]);
        @(negedge clk); drive(0, 4'b0, 32'h0, 32'h0);
        edge_sample();
        chk("bp_v_r2", {31'b0, v2}, 1);
        chk("bp_d_r2", d2, pre[2]);
        edge_sample();
        chk("bp_v_end", {31'b0, v2}, 0);
        repeat (3) edge_sample();

        // Async reset with two responses in flight on the RD_LAT=2 instance.
        @(negedge clk); drive(1, 4'b0, 32'h1c000020, 32'h0);
        @(negedge clk); drive(1, 4'b0, 32'h1c000024, 32'h0);
        @(posedge clk); #3;
        chk("ar_pre_v", {31'b0, v2}, 1);
        drive(0, 4'b0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        chk("ar_v_now", {31'b0, v2}, 0);
        chk("ar_d_now", d2, 0);
        chk("ar_rdy", {31'b0, rdy2}, 1);
        @(negedge clk); @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            edge_sample();
            chk($sformatf("ar_quiet%0d", k), {31'b0, v2}, 0);
        end
        @(negedge clk); drive(1, 4'b0, 32'h1c000010, 32'h0);
        edge_sample();
        chk("ar_keep_v", {31'b0, v1}, 1);
        chk("ar_keep_d", d1, 32'h1234AA55);
        chk("ar_keep_e", {31'b0, e1}, 0);
        @(negedge clk); drive(0, 4'b0, 32'h0, 32'h0);
        edge_sample();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
